// File: rtl/tt_matmul_pkg.sv
// Shared types and helpers for the streamed NxN matrix multiplier tile.
package tt_matmul_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int N_MAX  = 4;
    localparam int EW_MAX = 8;

    // Accumulator width: one full product plus headroom for summing N of them.
    function automatic int accw(input int n, input int ew);
        return 2 * ew + $clog2(n);
    endfunction

endpackage

// File: rtl/tt_matmul_stream_if.sv
// Element-in / result-out streaming handshake of the matrix multiplier tile.
interface tt_matmul_stream_if #(
    parameter int EW   = 4,
    parameter int ACCW = 10
);
    logic            in_valid;
    logic            in_ready;
    logic [EW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/tt_matmul_mac.sv
// Single multiply-accumulate unit shared over every k of every result element.
module tt_matmul_mac #(
    parameter int EW   = 4,
    parameter int ACCW = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr_acc,
    input  logic            signed_mode,
    input  logic [EW-1:0]   a,
    input  logic [EW-1:0]   b,
    output logic [ACCW-1:0] acc
);
    logic [ACCW-1:0] a_ext_s;
    logic [ACCW-1:0] b_ext_s;
    logic [ACCW-1:0] prod_s;
    logic [ACCW-1:0] acc_r;

    // Operand extension; the low ACCW bits of the product are exact in both modes.
    always_comb begin
        if (signed_mode) begin
            a_ext_s = {{(ACCW-EW){a[EW-1]}}, a};
            b_ext_s = {{(ACCW-EW){b[EW-1]}}, b};
        end else begin
            a_ext_s = {{(ACCW-EW){1'b0}}, a};
            b_ext_s = {{(ACCW-EW){1'b0}}, b};
        end
        prod_s = a_ext_s * b_ext_s;
    end

    // Accumulator register; clear wins over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {ACCW{1'b0}};
        end else if (clr_acc) begin
            acc_r <= {ACCW{1'b0}};
        end else if (en) begin
            acc_r <= acc_r + prod_s;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/tt_matmul_stream.sv
// Streamed NxN integer matrix multiplier: load A then B, compute C = A x B one element at a time.
module tt_matmul_stream
    import tt_matmul_pkg::*;
#(
    parameter int N  = 2,
    parameter int EW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clr,
    input  logic              mode_signed,
    output logic              busy,
    tt_matmul_stream_if.slave bus
);
    localparam int ACCW = accw(N, EW);
    localparam int NN   = N * N;
    localparam int IW   = $clog2(NN);
    localparam int LW   = $clog2(2 * N_MAX * N_MAX);
    localparam int CW   = $clog2(N_MAX);

    state_t          state_r, state_s;
    logic [LW-1:0]   ld_r, ld_s;
    logic [CW-1:0]   i_r, i_s, j_r, j_s, k_r, k_s;
    logic            mode_r, mode_s;
    logic            in_ready_s, in_xfer_s, out_valid_s, out_xfer_s;
    logic            mac_step_s, clr_acc_s;
    logic [EW-1:0]   a_mem_r [NN];
    logic [EW-1:0]   b_mem_r [NN];
    logic [IW-1:0]   a_idx_s, b_idx_s, wr_b_idx_s;
    logic [ACCW-1:0] acc_s;

    assign in_ready_s  = rst_n && ena && (state_r == LOAD);
    assign in_xfer_s   = bus.in_valid && in_ready_s && !clr;
    assign out_valid_s = ena && (state_r == OUT);
    assign out_xfer_s  = out_valid_s && bus.out_ready && !clr;

    // Next-state, counter and MAC-control decode.
    always_comb begin
        state_s    = state_r;
        ld_s       = ld_r;
        i_s        = i_r;
        j_s        = j_r;
        k_s        = k_r;
        mode_s     = mode_r;
        mac_step_s = 1'b0;
        clr_acc_s  = 1'b0;
        if (clr) begin
            state_s   = LOAD;
            ld_s      = {LW{1'b0}};
            i_s       = {CW{1'b0}};
            j_s       = {CW{1'b0}};
            k_s       = {CW{1'b0}};
            clr_acc_s = 1'b1;
        end else begin
            case (state_r)
                LOAD: begin
                    if (in_xfer_s) begin
                        if (ld_r == {LW{1'b0}}) begin
                            mode_s = mode_signed;
                        end else begin
                            mode_s = mode_r;
                        end
                        if (ld_r == LW'(2 * NN - 1)) begin
                            state_s   = MAC;
                            ld_s      = {LW{1'b0}};
                            i_s       = {CW{1'b0}};
                            j_s       = {CW{1'b0}};
                            k_s       = {CW{1'b0}};
                            clr_acc_s = 1'b1;
                        end else begin
                            ld_s = ld_r + LW'(1);
                        end
                    end else begin
                        ld_s = ld_r;
                    end
                end
                MAC: begin
                    mac_step_s = 1'b1;
                    if (k_r == CW'(N - 1)) begin
                        k_s     = {CW{1'b0}};
                        state_s = OUT;
                    end else begin
                        k_s = k_r + CW'(1);
                    end
                end
                OUT: begin
                    if (out_xfer_s) begin
                        if ((i_r == CW'(N - 1)) && (j_r == CW'(N - 1))) begin
                            state_s = LOAD;
                            i_s     = {CW{1'b0}};
                            j_s     = {CW{1'b0}};
                        end else begin
                            state_s   = MAC;
                            clr_acc_s = 1'b1;
                            if (j_r == CW'(N - 1)) begin
                                j_s = {CW{1'b0}};
                                i_s = i_r + CW'(1);
                            end else begin
                                j_s = j_r + CW'(1);
                            end
                        end
                    end else begin
                        state_s = OUT;
                    end
                end
                default: begin
                    state_s = LOAD;
                end
            endcase
        end
    end

    // State and counter registers; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD;
            ld_r    <= {LW{1'b0}};
            i_r     <= {CW{1'b0}};
            j_r     <= {CW{1'b0}};
            k_r     <= {CW{1'b0}};
            mode_r  <= 1'b0;
        end else if (ena) begin
            state_r <= state_s;
            ld_r    <= ld_s;
            i_r     <= i_s;
            j_r     <= j_s;
            k_r     <= k_s;
            mode_r  <= mode_s;
        end
    end

    assign wr_b_idx_s = IW'(ld_r - LW'(NN));

    // A/B storage in arrival order; unreset since every LOAD overwrites all of it.
    always_ff @(posedge clk) begin
        if (in_xfer_s) begin
            if (ld_r < LW'(NN)) begin
                a_mem_r[ld_r[IW-1:0]] <= bus.in_data;
            end else begin
                b_mem_r[wr_b_idx_s] <= bus.in_data;
            end
        end
    end

    assign a_idx_s = IW'(int'(i_r) * N + int'(k_r));
    assign b_idx_s = IW'(int'(k_r) * N + int'(j_r));

    tt_matmul_mac #(
        .EW   (EW),
        .ACCW (ACCW)
    ) u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (ena && mac_step_s),
        .clr_acc     (ena && clr_acc_s),
        .signed_mode (mode_r),
        .a           (a_mem_r[a_idx_s]),
        .b           (b_mem_r[b_idx_s]),
        .acc         (acc_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = acc_s;
    assign busy          = (state_r != LOAD);

endmodule

// File: tb/tb_tt_matmul_stream.sv
// Self-checking bench: 2x2/4-bit vector table plus handshake corner sequences, and a 3x3/8-bit model run.
module tb_tt_matmul_stream;
    import tt_matmul_pkg::*;

    localparam int AW2 = accw(2, 4);
    localparam int AW3 = accw(3, 8);

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        logic [35:0] c;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic clr = 1'b0;
    logic mode_signed = 1'b0;
    logic mode_signed3 = 1'b0;
    logic busy, busy3;

    vec_t           tbl [5];
    logic [AW2-1:0] exp_q [$];
    logic [AW3-1:0] exp3_q [$];
    logic [7:0]     a3 [9];
    logic [7:0]     b3 [9];
    int             checks = 0;
    int             failures = 0;

    always #5 clk = ~clk;

    tt_matmul_stream_if #(.EW(4), .ACCW(AW2)) s ();
    tt_matmul_stream_if #(.EW(8), .ACCW(AW3)) s3 ();

    tt_matmul_stream #(.N(2), .EW(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .mode_signed(mode_signed), .busy(busy), .bus(s)
    );

    tt_matmul_stream #(.N(3), .EW(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .mode_signed(mode_signed3), .busy(busy3), .bus(s3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboards: a result is compared on the falling edge before the edge that transfers it.
    always @(negedge clk) begin
        if (rst_n && ena && !clr && s.out_valid && s.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL c2_unexpected: got %0d expected none", s.out_data);
            end else begin
                chk("c2_result", 32'(s.out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ena && !clr && s3.out_valid && s3.out_ready) begin
            if (exp3_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL c3_unexpected: got %0d expected none", s3.out_data);
            end else begin
                chk("c3_result", 32'(s3.out_data), 32'(exp3_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [3:0] d);
        int n = 0;
        s.in_valid = 1'b1;
        s.in_data  = d;
        @(negedge clk);
        while (!s.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(s.in_ready), 32'd1);
        @(posedge clk);
        #1;
        s.in_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] d);
        int n = 0;
        s3.in_valid = 1'b1;
        s3.in_data  = d;
        @(negedge clk);
        while (!s3.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready3_wait", 32'(s3.in_ready), 32'd1);
        @(posedge clk);
        #1;
        s3.in_valid = 1'b0;
    endtask

    task automatic push_vec(input vec_t v);
        for (int e = 0; e < 4; e++) exp_q.push_back(v.c[e*9 +: 9]);
    endtask

    // Loads A then B; mode_signed is flipped after element 0 and must be ignored.
    task automatic load_vec(input vec_t v, input int gap_at);
        logic [3:0] d;
        mode_signed = v.sgn;
        for (int e = 0; e < 8; e++) begin
            if (e == gap_at) begin
                ena = 1'b0;
                s.in_valid = 1'b1;
                s.in_data = 4'hF;
                repeat (3) begin
                    @(negedge clk);
                    chk("ena_low_in_ready", 32'(s.in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                ena = 1'b1;
            end
            if (e < 4) d = v.a[e*4 +: 4];
            else       d = v.b[(e-4)*4 +: 4];
            send(d);
            if (e == 0) mode_signed = ~v.sgn;
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!s.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(s.out_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || exp3_q.size() != 0 || busy || busy3) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_pending"}, 32'(exp_q.size() + exp3_q.size()), 32'd0);
        chk({name, "_busy"}, 32'(busy | busy3), 32'd0);
    endtask

    task automatic run3(input logic sgn);
        int av, bv, sum;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum = 0;
                for (int k = 0; k < 3; k++) begin
                    av = sgn ? int'($signed(a3[i*3+k])) : int'(a3[i*3+k]);
                    bv = sgn ? int'($signed(b3[k*3+j])) : int'(b3[k*3+j]);
                    sum += av * bv;
                end
                exp3_q.push_back(AW3'(sum));
            end
        end
        mode_signed3 = sgn;
        for (int e = 0; e < 18; e++) begin
            if (e < 9) send3(a3[e]);
            else       send3(b3[e-9]);
        end
        wait_idle("n3");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{a: 16'h4321, b: 16'h1001, sgn: 1'b0, c: {9'd4, 9'd3, 9'd2, 9'd1}};
        tbl[1] = '{a: 16'hFFFF, b: 16'hFFFF, sgn: 1'b0, c: {4{9'd450}}};
        tbl[2] = '{a: 16'h8888, b: 16'h8888, sgn: 1'b1, c: {4{9'd128}}};
        // 4'h8 reads as -8 when signed, so C[0][1] = -10 and C[1][1] = 14.
        tbl[3] = '{a: 16'hC32F, b: 16'h87A5, sgn: 1'b1, c: {9'd14, 9'h1F3, 9'h1F6, 9'd9}};
        tbl[4] = '{a: 16'hC32F, b: 16'h87A5, sgn: 1'b0, c: {9'd126, 9'd99, 9'd166, 9'd89}};

        s.in_valid = 1'b0;  s.in_data = 4'h0;  s.out_ready = 1'b1;
        s3.in_valid = 1'b0; s3.in_data = 8'h00; s3.out_ready = 1'b1;
        ena = 1'b1;
        #12;
        chk("rst_in_ready", 32'(s.in_ready), 32'd0);
        chk("rst_out_valid", 32'(s.out_valid), 32'd0);
        chk("rst_out_data", 32'(s.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(s.in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            push_vec(tbl[v]);
            load_vec(tbl[v], -1);
            chk("mac_busy", 32'(busy), 32'd1);
            chk("mac_in_ready", 32'(s.in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("latency_not_early", 32'(s.out_valid), 32'd0);
            @(posedge clk);
            #1;
            chk("latency_first_valid", 32'(s.out_valid), 32'd1);
            wait_idle("table");
        end

        // Backpressure on C[0][1] with in_valid pulses that must be ignored.
        push_vec(tbl[0]);
        load_vec(tbl[0], -1);
        for (int n = 0; n < 20 && exp_q.size() != 3; n++) @(negedge clk);
        chk("bp_first_popped", 32'(exp_q.size()), 32'd3);
        @(posedge clk);
        #1;
        s.out_ready = 1'b0;
        wait_valid("bp_c01_valid");
        repeat (5) begin
            s.in_valid = 1'b1;
            s.in_data = 4'h7;
            @(negedge clk);
            chk("bp_hold_valid", 32'(s.out_valid), 32'd1);
            chk("bp_hold_data", 32'(s.out_data), 32'd2);
            chk("bp_in_ready", 32'(s.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        s.in_valid = 1'b0;
        s.out_ready = 1'b1;
        wait_idle("bp");

        // Soft clear during MAC, then a clean reload.
        load_vec(tbl[1], -1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_in_ready", 32'(s.in_ready), 32'd1);
        chk("clr_out_valid", 32'(s.out_valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("clr_stays_idle", 32'(s.out_valid), 32'd0);
        push_vec(tbl[3]);
        load_vec(tbl[3], -1);
        wait_idle("clr_reload");

        // Asynchronous reset while a result is pending.
        s.out_ready = 1'b0;
        load_vec(tbl[0], -1);
        wait_valid("rst_out_pending");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(s.out_valid), 32'd0);
        chk("async_rst_data", 32'(s.out_data), 32'd0);
        chk("async_rst_in_ready", 32'(s.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("async_rel_in_ready", 32'(s.in_ready), 32'd1);
        s.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // ena dropped mid-load (inside load_vec) and mid-OUT.
        s.out_ready = 1'b0;
        push_vec(tbl[0]);
        load_vec(tbl[0], 3);
        wait_valid("ena_c00_valid");
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("ena_out_valid", 32'(s.out_valid), 32'd0);
            chk("ena_out_data", 32'(s.out_data), 32'd1);
            chk("ena_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        ena = 1'b1;
        s.out_ready = 1'b1;
        wait_idle("ena");

        // 3x3, 8-bit instance against the reference model.
        a3 = '{8'hFF, 8'd2, 8'd0, 8'd3, 8'hFC, 8'd0, 8'd0, 8'd0, 8'd1};
        b3 = '{8'd5, 8'hFA, 8'd0, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'h80};
        run3(1'b1);
        for (int e = 0; e < 9; e++) begin
            a3[e] = 8'hFF;
            b3[e] = 8'hFF;
        end
        run3(1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int e = 0; e < 9; e++) begin
                a3[e] = 8'($urandom_range(0, 255));
                b3[e] = 8'($urandom_range(0, 255));
            end
            run3(r == 0 ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
